// File: rtl/tb_best_state_search.sv
// Traceback start-state finder: scans 2**K path metrics LANES per cycle
// and reports the minimum-metric state, its metric and a tie flag.
module tb_best_state_search #(
  parameter int W     = 8,
  parameter int K     = 3,
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               force_zero_i,
  input  logic [W*(2**K)-1:0] metrics_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [K-1:0]       best_state_o,
  output logic [W-1:0]       best_metric_o,
  output logic               tie_o
);

  localparam int NS  = 2**K;
  localparam int NCH = NS / LANES;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [W*NS-1:0] mreg;
  logic [CW-1:0]   chunk;
  logic [W-1:0]    run_metric;
  logic [K-1:0]    run_state;
  logic            run_tie;

  logic [W-1:0] lane;
  logic [W-1:0] chunk_min;
  logic [K-1:0] chunk_idx;
  logic         chunk_multi;

  logic [W-1:0] nxt_metric;
  logic [K-1:0] nxt_state;
  logic         nxt_tie;

  logic accept;
  logic last;

  assign accept = start_i && (state_q != SCAN);
  assign last   = (chunk == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = force_zero_i ? DONE : SCAN;
        else         state_d = IDLE;
      end
      SCAN:    if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == SCAN);
    done_o = (state_q == DONE);
  end

  // Chunk reduction: lowest index wins, then look for a second equal minimum
  always_comb begin
    lane        = '0;
    chunk_min   = '0;
    chunk_idx   = '0;
    chunk_multi = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane = mreg[W*(int'(chunk)*LANES+i) +: W];
      if (i == 0 || lane < chunk_min) begin
        chunk_min = lane;
        chunk_idx = K'(int'(chunk)*LANES+i);
      end
    end
    for (int i = 0; i < LANES; i++) begin
      lane = mreg[W*(int'(chunk)*LANES+i) +: W];
      if (lane == chunk_min && K'(int'(chunk)*LANES+i) != chunk_idx)
        chunk_multi = 1'b1;
    end
  end

  // Chunk 0 loads outright so state 0 never ties with itself
  always_comb begin
    nxt_metric = run_metric;
    nxt_state  = run_state;
    nxt_tie    = run_tie;
    unique case (1'b1)
      (chunk == '0): begin
        nxt_metric = chunk_min;
        nxt_state  = chunk_idx;
        nxt_tie    = chunk_multi;
      end
      (chunk != '0) && (chunk_min < run_metric): begin
        nxt_metric = chunk_min;
        nxt_state  = chunk_idx;
        nxt_tie    = chunk_multi;
      end
      (chunk != '0) && (chunk_min == run_metric): begin
        nxt_tie = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreg          <= '0;
      chunk         <= '0;
      run_metric    <= '0;
      run_state     <= '0;
      run_tie       <= 1'b0;
      best_state_o  <= '0;
      best_metric_o <= '0;
      tie_o         <= 1'b0;
    end else if (accept) begin
      mreg       <= metrics_i;
      chunk      <= '0;
      run_metric <= metrics_i[W-1:0];
      run_state  <= '0;
      run_tie    <= 1'b0;
      if (force_zero_i) begin
        best_state_o  <= '0;
        best_metric_o <= metrics_i[W-1:0];
        tie_o         <= 1'b0;
      end
    end else if (state_q == SCAN) begin
      run_metric <= nxt_metric;
      run_state  <= nxt_state;
      run_tie    <= nxt_tie;
      if (last) begin
        chunk         <= '0;
        best_state_o  <= nxt_state;
        best_metric_o <= nxt_metric;
        tie_o         <= nxt_tie;
      end else begin
        chunk <= chunk + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tb_best_state_search.sv
// Scoreboard bench: three lane configurations, directed metric vectors,
// expected results queued at issue and checked when done_o fires.
module tb_tb_best_state_search;

  typedef struct {
    logic [2:0] st;
    logic [7:0] met;
    logic       tie;
    int         cyc;
    int         busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        force_zero = 1'b0;
  logic [63:0] metrics = '0;

  logic       busy2, done2, tie2;
  logic [2:0] st2;
  logic [7:0] met2;
  logic       busy1, done1, tie1;
  logic [2:0] st1;
  logic [7:0] met1;
  logic       busy8, done8, tie8;
  logic [2:0] st8;
  logic [7:0] met8;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int bc2 = 0, bc1 = 0, bc8 = 0;
  exp_t q2[$], q1[$], q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tb_best_state_search #(.W(8), .K(3), .LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_a),
    .force_zero_i(force_zero), .metrics_i(metrics),
    .busy_o(busy2), .done_o(done2), .best_state_o(st2),
    .best_metric_o(met2), .tie_o(tie2)
  );

  tb_best_state_search #(.W(8), .K(3), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_b),
    .force_zero_i(force_zero), .metrics_i(metrics),
    .busy_o(busy1), .done_o(done1), .best_state_o(st1),
    .best_metric_o(met1), .tie_o(tie1)
  );

  tb_best_state_search #(.W(8), .K(3), .LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .start_i(start_b),
    .force_zero_i(force_zero), .metrics_i(metrics),
    .busy_o(busy8), .done_o(done8), .best_state_o(st8),
    .best_metric_o(met8), .tie_o(tie8)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [63:0] vec(
    input logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7
  );
    return {s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(
    input logic [2:0] st, input logic [7:0] met, input logic tie,
    input int lat, input int busy
  );
    exp_t e;
    e.st   = st;
    e.met  = met;
    e.tie  = tie;
    e.cyc  = cyc + lat;
    e.busy = busy;
    return e;
  endfunction

  // Drive one start for a cycle; queue expectations for the chosen DUTs
  task automatic issue(
    input logic [63:0] v, input logic fz, input logic a, input logic b,
    input logic push, input logic [2:0] st, input logic [7:0] met,
    input logic tie
  );
    if (push && a) q2.push_back(mk(st, met, tie, fz ? 1 : 5, fz ? 0 : 4));
    if (push && b) q1.push_back(mk(st, met, tie, 9, 8));
    if (push && b) q8.push_back(mk(st, met, tie, 2, 1));
    metrics    = v;
    force_zero = fz;
    start_a    = a;
    start_b    = b;
    tick();
    start_a    = 1'b0;
    start_b    = 1'b0;
    force_zero = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bc2 = 0;
    else if (done2) begin
      if (q2.size() == 0) chk("l2_unexpected_done", 1, 0);
      else begin
        e = q2.pop_front();
        chk("l2_state", st2, e.st);
        chk("l2_metric", met2, e.met);
        chk("l2_tie", tie2, e.tie);
        chk("l2_done_cycle", cyc, e.cyc);
        chk("l2_busy_cycles", bc2, e.busy);
      end
      bc2 = 0;
    end else if (busy2) bc2++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bc1 = 0;
    else if (done1) begin
      if (q1.size() == 0) chk("l1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("l1_state", st1, e.st);
        chk("l1_metric", met1, e.met);
        chk("l1_tie", tie1, e.tie);
        chk("l1_done_cycle", cyc, e.cyc);
        chk("l1_busy_cycles", bc1, e.busy);
      end
      bc1 = 0;
    end else if (busy1) bc1++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bc8 = 0;
    else if (done8) begin
      if (q8.size() == 0) chk("l8_unexpected_done", 1, 0);
      else begin
        e = q8.pop_front();
        chk("l8_state", st8, e.st);
        chk("l8_metric", met8, e.met);
        chk("l8_tie", tie8, e.tie);
        chk("l8_done_cycle", cyc, e.cyc);
        chk("l8_busy_cycles", bc8, e.busy);
      end
      bc8 = 0;
    end else if (busy8) bc8++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] v1, v2, v3, v4, v7;
    v1 = vec(10, 12, 3, 15, 3, 9, 8, 7);
    v2 = vec(8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
    v3 = vec(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    v4 = vec(8'h20, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h40, 8'h40);
    v7 = vec(50, 2, 50, 50, 50, 50, 2, 50);

    repeat (3) tick();
    chk("reset_state", st2, 0);
    chk("reset_metric", met2, 0);
    chk("reset_tie", tie2, 0);
    chk("reset_busy", busy2, 0);
    chk("reset_done", done2, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Tests 1-3 on all three lane widths
    issue(v1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'd3, 1'b1);
    repeat (12) tick();
    issue(v2, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'h55, 1'b1);
    repeat (12) tick();
    issue(v3, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0);
    repeat (12) tick();
    issue(v7, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'd2, 1'b1);
    repeat (12) tick();

    // Test 4: terminated trellis
    issue(v4, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h20, 1'b0);
    repeat (6) tick();

    // Test 5: start in SCAN ignored, start in DONE accepted
    issue(v1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'd3, 1'b1);
    tick();
    metrics = v2;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (2) tick();
    chk("t5_in_done_cycle", done2, 1);
    issue(v7, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'd2, 1'b1);
    repeat (12) tick();

    // Test 6: reset during SCAN cycle 2 aborts the search
    issue(v3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_state", st2, 0);
    chk("abort_metric", met2, 0);
    chk("abort_tie", tie2, 0);
    chk("abort_busy", busy2, 0);
    chk("abort_done", done2, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    issue(v1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'd3, 1'b1);
    repeat (12) tick();

    chk("q2_drained", q2.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
